// File: rtl/jet_ts_pkg.sv
// Shared types and constants for the jet trigger slice datapath.
// Cluster word layout: {ntrx[22:18], xcount[17:14], eta[13:9], pt[8:0]}.
package jet_ts_pkg;

   localparam int unsigned CW       = 23;
   localparam int unsigned PTBITS   = 9;
   localparam int unsigned SUMW     = PTBITS + 4;
   localparam int unsigned PT_LSB   = 0;
   localparam int unsigned ETA_LSB  = 9;
   localparam int unsigned XC_LSB   = 14;
   localparam int unsigned NTRX_LSB = 18;

   typedef enum logic [3:0] {
      FREE  = 4'b0001,
      FILL  = 4'b0010,
      FULL  = 4'b0100,
      DRAIN = 4'b1000
   } bank_state_e;

   // Event pT accumulation clamps at all-ones instead of wrapping.
   function automatic logic [SUMW-1:0] sat_add(input logic [SUMW-1:0] a,
                                               input logic [PTBITS-1:0] b);
      logic [SUMW:0] s;
      s = (SUMW+1)'(a) + (SUMW+1)'(b);
      return s[SUMW] ? {SUMW{1'b1}} : s[SUMW-1:0];
   endfunction

endpackage

// File: rtl/cluster_bank.sv
// One ping-pong bank: cluster storage, word count, pT sum, truncation flag and
// FREE/FILL/FULL/DRAIN state. Commands from the top are gated by the bank's own state.
module cluster_bank
   import jet_ts_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CNTW  = $clog2(DEPTH + 1),
   localparam int unsigned IDXW  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [CW-1:0]     wr_data,
   input  logic              close,
   input  logic              abort,
   input  logic              drain_start,
   input  logic              rel,
   input  logic [IDXW-1:0]   rd_idx,
   output bank_state_e       state,
   output logic [CNTW-1:0]   count,
   output logic [SUMW-1:0]   sum,
   output logic              trunc,
   output logic [CW-1:0]     rd_word
);

   bank_state_e       state_q, state_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic [SUMW-1:0]   sum_q, sum_d;
   logic              trunc_q, trunc_d;
   logic [CW-1:0]     mem_q [DEPTH];
   logic [CW-1:0]     mem_d [DEPTH];

   // Abort, then write, then close: a word arriving with the done edge belongs to the event.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sum_d   = sum_q;
      trunc_d = trunc_q;
      mem_d   = mem_q;
      if (abort && state_q == FILL) begin
         state_d = FREE;
         count_d = '0;
         sum_d   = '0;
         trunc_d = 1'b0;
      end
      if (wr_en && (state_d == FREE || state_d == FILL)) begin
         if (count_d < CNTW'(DEPTH)) begin
            mem_d[IDXW'(count_d)] = wr_data;
            count_d = count_d + CNTW'(1);
            sum_d   = sat_add(sum_d, wr_data[PT_LSB +: PTBITS]);
         end else begin
            trunc_d = 1'b1;
         end
         state_d = FILL;
      end
      if (close && (state_d == FREE || state_d == FILL)) state_d = FULL;
      if (drain_start && state_q == FULL) state_d = DRAIN;
      if (rel && state_q == DRAIN) begin
         state_d = FREE;
         count_d = '0;
         sum_d   = '0;
         trunc_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FREE;
         count_q <= '0;
         sum_q   <= '0;
         trunc_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         trunc_q <= trunc_d;
         mem_q   <= mem_d;
      end
   end

   assign state   = state_q;
   assign count   = count_q;
   assign sum     = sum_q;
   assign trunc   = trunc_q;
   assign rd_word = mem_q[rd_idx];

endmodule

// File: rtl/phi_cluster_buffer.sv
// Per-phi-slice ping-pong cluster buffer between L1 clustering and the merge stage.
// Holds write/read bank selectors, done-edge detection, drain sequencing and overflow.
module phi_cluster_buffer
   import jet_ts_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              evt_start,
   input  logic [CW-1:0]     l1_cluster_in,
   input  logic              l1_cluster_vld,
   input  logic              phi_done,
   output logic              mj_ready,
   output logic [CW-1:0]     out_cluster,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              out_null,
   output logic [SUMW-1:0]   out_pt_sum,
   output logic              overflow
);

   localparam int unsigned CNTW = $clog2(DEPTH + 1);
   localparam int unsigned IDXW = $clog2(DEPTH);

   logic              done_q, done_d;
   logic              wb_q, wb_d;
   logic              rb_q, rb_d;
   logic [IDXW-1:0]   rptr_q, rptr_d;
   logic              overflow_q, overflow_d;

   bank_state_e       st      [2];
   logic [CNTW-1:0]   cnt     [2];
   logic [SUMW-1:0]   bsum    [2];
   logic              trunc   [2];
   logic [CW-1:0]     rd_word [2];

   logic wr_open_c, done_edge_c, valid_c, null_c, last_c, accept_c, drain_go_c;

   always_comb begin
      wr_open_c   = (st[wb_q] == FREE) || (st[wb_q] == FILL);
      done_edge_c = phi_done & ~done_q;
      valid_c     = (st[rb_q] == DRAIN);
      null_c      = valid_c && (cnt[rb_q] == '0);
      last_c      = valid_c && (null_c || (CNTW'(rptr_q) == cnt[rb_q] - CNTW'(1)));
      accept_c    = valid_c & out_ready;
      drain_go_c  = (st[rb_q] == FULL);
   end

   // Selector and pointer updates; wb flips the cycle after a bank is closed.
   always_comb begin
      done_d     = phi_done;
      wb_d       = wb_q ^ (done_edge_c & wr_open_c);
      rb_d       = rb_q;
      rptr_d     = rptr_q;
      overflow_d = overflow_q | trunc[0] | trunc[1]
                 | (~wr_open_c & (l1_cluster_vld | done_edge_c));
      if (drain_go_c) begin
         rptr_d = '0;
      end else if (accept_c) begin
         if (last_c) begin
            rptr_d = '0;
            rb_d   = ~rb_q;
         end else begin
            rptr_d = rptr_q + IDXW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q     <= 1'b0;
         wb_q       <= 1'b0;
         rb_q       <= 1'b0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         done_q     <= done_d;
         wb_q       <= wb_d;
         rb_q       <= rb_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      cluster_bank #(.DEPTH(DEPTH)) u_bank (
         .clk         (clk),
         .reset       (reset),
         .wr_en       (l1_cluster_vld && (wb_q == 1'(b))),
         .wr_data     (l1_cluster_in),
         .close       (done_edge_c && (wb_q == 1'(b))),
         .abort       (evt_start && (wb_q == 1'(b))),
         .drain_start (drain_go_c && (rb_q == 1'(b))),
         .rel         (accept_c && last_c && (rb_q == 1'(b))),
         .rd_idx      (rptr_q),
         .state       (st[b]),
         .count       (cnt[b]),
         .sum         (bsum[b]),
         .trunc       (trunc[b]),
         .rd_word     (rd_word[b])
      );
   end

   assign mj_ready    = wr_open_c;
   assign out_valid   = valid_c;
   assign out_last    = last_c;
   assign out_null    = null_c;
   assign out_cluster = (valid_c && !null_c) ? rd_word[rb_q] : '0;
   assign out_pt_sum  = last_c ? bsum[rb_q] : '0;
   assign overflow    = overflow_q;

endmodule
